// File: rtl/ps2_keyboard_rx_if.sv
// ==========================================================================
// Module : ps2_keyboard_rx_if
// Brief  : PS/2 pin inputs and decoded key-event outputs of ps2_keyboard_rx
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

interface ps2_keyboard_rx_if;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic [7:0] scancode_out;
  logic       extended_out;
  logic       release_out;
  logic       valid_out;
  logic       error_out;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    input  scancode_out,
    input  extended_out,
    input  release_out,
    input  valid_out,
    input  error_out
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    output scancode_out,
    output extended_out,
    output release_out,
    output valid_out,
    output error_out
  );
endinterface

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ==========================================================================
// Module : ps2_keyboard_rx
// Brief  : PS/2 keyboard frame receiver with E0/F0 prefix folding
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 150000
) (
  input wire logic         clk_in,
  input wire logic         rst_in,
  ps2_keyboard_rx_if.slave bus
);

  localparam int                c_TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0]   c_TIMEOUT   = c_TW'(TIMEOUT_CYCLES);
  localparam logic [c_TW-1:0]   c_TIMER_ONE = c_TW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_clk_s1, r_clk_s2, r_clk_s3;
  logic            r_data_s1, r_data_s2;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_parity;
  logic [c_TW-1:0] r_timer;
  logic            r_ext_pend, r_rel_pend;
  logic [7:0]      r_scancode;
  logic            r_extended, r_release, r_valid, r_error;
  logic            w_fall, w_byte_good, w_frame_err, w_timeout;

  assign w_fall = r_clk_s3 & ~r_clk_s2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A falling edge takes priority over a coincident timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_byte_good = 1'b0;
    w_frame_err = 1'b0;
    w_timeout   = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_data_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_data_s2 && (^{r_shift, r_parity})) w_byte_good = 1'b1;
          else                                       w_frame_err = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end else if ((r_state != S_IDLE) && (r_timer == c_TIMEOUT)) begin
      w_state_nxt = S_IDLE;
      w_timeout   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_s3   <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_parity   <= 1'b0;
      r_timer    <= '0;
      r_ext_pend <= 1'b0;
      r_rel_pend <= 1'b0;
      r_scancode <= 8'h00;
      r_extended <= 1'b0;
      r_release  <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_clk_s1  <= bus.ps2_clk_in;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_data_s1 <= bus.ps2_data_in;
      r_data_s2 <= r_data_s1;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;

      if (w_fall || (r_state == S_IDLE)) r_timer <= '0;
      else if (r_timer != c_TIMEOUT)     r_timer <= r_timer + c_TIMER_ONE;

      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_shift   <= {r_data_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= r_data_s2;
          default:  ;
        endcase
      end

      if (w_frame_err || w_timeout) begin
        r_error    <= 1'b1;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end

      if (w_byte_good) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_rel_pend <= 1'b1;
        end else begin
          r_scancode <= r_shift;
          r_extended <= r_ext_pend;
          r_release  <= r_rel_pend;
          r_valid    <= 1'b1;
          r_ext_pend <= 1'b0;
          r_rel_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.scancode_out = r_scancode;
  assign bus.extended_out = r_extended;
  assign bus.release_out  = r_release;
  assign bus.valid_out    = r_valid;
  assign bus.error_out    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ==========================================================================
// Module : tb_ps2_keyboard_rx
// Brief  : Scoreboard bench for ps2_keyboard_rx (scaled-down PS/2 bit rate)
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module tb_ps2_keyboard_rx;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   latency    = 0;
  ev_t  sb[$];

  ps2_keyboard_rx_if bus_if ();

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard consumer: every strobe must match the oldest expected event.
  always @(negedge clk_in) begin
    ev_t e;
    if (!rst_in && (bus_if.valid_out || bus_if.error_out)) begin
      compared++;
      if (bus_if.valid_out && bus_if.error_out) begin
        mismatched++;
        $display("FAIL strobe_overlap: valid=1 error=1, required only one");
      end else if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe: valid=%b error=%b code=%h, required none",
                 bus_if.valid_out, bus_if.error_out, bus_if.scancode_out);
      end else begin
        e = sb.pop_front();
        if (e.err) begin
          if (!bus_if.error_out) begin
            mismatched++;
            $display("FAIL event_kind: got valid strobe code=%h, required error strobe",
                     bus_if.scancode_out);
          end
        end else if (!bus_if.valid_out ||
                     bus_if.scancode_out !== e.code ||
                     bus_if.extended_out !== e.ext  ||
                     bus_if.release_out  !== e.rel) begin
          mismatched++;
          $display("FAIL event: got v=%b code=%h ext=%b rel=%b, required code=%h ext=%b rel=%b",
                   bus_if.valid_out, bus_if.scancode_out, bus_if.extended_out,
                   bus_if.release_out, e.code, e.ext, e.rel);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    bus_if.ps2_data_in = b;
    repeat (HALF) @(negedge clk_in);
    bus_if.ps2_clk_in = 1'b0;
    repeat (HALF) @(negedge clk_in);
    bus_if.ps2_clk_in = 1'b1;
  endtask

  // The timed stop-bit path drops the clock 2 time units before a clk_in edge.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic bad_stop, input logic timed);
    logic par;
    logic found;
    par = (~^d) ^ bad_par;
    repeat (HALF) @(negedge clk_in);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    if (!timed) begin
      ps2_bit(~bad_stop);
    end else begin
      bus_if.ps2_data_in = ~bad_stop;
      repeat (HALF) @(negedge clk_in);
      @(posedge clk_in);
      #8 bus_if.ps2_clk_in = 1'b0;
      found   = 1'b0;
      latency = 0;
      for (int n = 1; n <= 6; n++) begin
        @(posedge clk_in);
        #1;
        if (!found && bus_if.valid_out) begin
          found   = 1'b1;
          latency = n;
        end
      end
      repeat (HALF) @(negedge clk_in);
      bus_if.ps2_clk_in = 1'b1;
    end
    bus_if.ps2_data_in = 1'b1;
  endtask

  task automatic push_ev(input logic err, input logic [7:0] code,
                         input logic ext, input logic rel);
    ev_t e;
    e.err = err; e.code = code; e.ext = ext; e.rel = rel;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      @(negedge clk_in);
      guard++;
    end
    repeat (5) @(negedge clk_in);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_missing: %0d expected events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_outputs(input string name, input logic [7:0] code,
                               input logic ext, input logic rel);
    compared++;
    if (bus_if.scancode_out !== code || bus_if.extended_out !== ext ||
        bus_if.release_out !== rel) begin
      mismatched++;
      $display("FAIL %s: got code=%h ext=%b rel=%b, required code=%h ext=%b rel=%b",
               name, bus_if.scancode_out, bus_if.extended_out, bus_if.release_out,
               code, ext, rel);
    end
  endtask

  task automatic test_reset();
    bus_if.ps2_clk_in  = 1'b1;
    bus_if.ps2_data_in = 1'b1;
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check_outputs("reset_outputs", 8'h00, 1'b0, 1'b0);
    compared++;
    if (bus_if.valid_out !== 1'b0 || bus_if.error_out !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: valid=%b error=%b, required 0 0",
               bus_if.valid_out, bus_if.error_out);
    end
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_make_code();
    push_ev(1'b0, 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drain("make_1c");
    push_ev(1'b0, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    drain("make_a5");
  endtask

  task automatic test_break_extended();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b0, 8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    drain("break_1c");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b0, 8'h6B, 1'b1, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b0, 1'b0);
    drain("f0_e0_e0_6b");
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b0, 8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    drain("e0_f0_75");
  endtask

  task automatic test_frame_errors();
    push_ev(1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drain("parity_err");
    check_outputs("parity_err_hold", 8'h75, 1'b1, 1'b1);
    push_ev(1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    drain("stop_err");
    push_ev(1'b0, 8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    drain("after_stop_err");
  endtask

  task automatic test_timeout();
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    push_ev(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk_in);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    repeat (TIMEOUT + 10) @(negedge clk_in);
    drain("timeout");
    push_ev(1'b0, 8'h66, 1'b0, 1'b0);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0);
    drain("after_timeout");
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk_in);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_outputs("midframe_reset", 8'h00, 1'b0, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk_in);
    push_ev(1'b0, 8'h74, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0, 1'b0);
    drain("after_reset");
  endtask

  task automatic test_latency();
    push_ev(1'b0, 8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0, 1'b1);
    drain("latency_event");
    compared++;
    if (latency !== 3) begin
      mismatched++;
      $display("FAIL latency: got %0d clk_in edges, required 3", latency);
    end
  endtask

  task automatic test_back_to_back();
    push_ev(1'b0, 8'h12, 1'b0, 1'b0);
    push_ev(1'b0, 8'h34, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(i == 2 || i == 4 || i == 5);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_make_code();
    test_break_extended();
    test_frame_errors();
    test_timeout();
    test_reset_midframe();
    test_latency();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
